// File: rtl/lampFPU_pkg.sv
// ---------------------------------------------------------------------------
// lampFPU_pkg
// Shared types and constants for the LAMP square-root issue unit:
//   state_t   - controller states
//   class_t   - bfloat16 operand classification {is_zero, is_inf, is_nan, sign}
//   classify  - builds a class_t from a raw bfloat16 word
//   CANON_QNAN, POS_INF, BIAS
// ---------------------------------------------------------------------------
package lampFPU_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_PACK,
        ST_OUT
    } state_t;

    localparam logic [15:0]        CANON_QNAN = 16'h7FC0;
    localparam logic [15:0]        POS_INF    = 16'h7F80;
    localparam logic signed [9:0]  BIAS       = 10'sd127;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic sign;
    } class_t;

    // Denormals (exponent field 0) are flushed and reported as zero.
    function automatic class_t classify(input logic [15:0] op);
        class_t c;
        c.sign    = op[15];
        c.is_zero = (op[14:7] == 8'h00);
        c.is_inf  = (op[14:7] == 8'hFF) && (op[6:0] == 7'd0);
        c.is_nan  = (op[14:7] == 8'hFF) && (op[6:0] != 7'd0);
        return c;
    endfunction

endpackage

// File: rtl/lamp_sqrt_round_pack.sv
// ---------------------------------------------------------------------------
// lamp_sqrt_round_pack
// Combinational normalize / round-to-nearest-even / pack of the core's
// Q1.15 significand into a positive bfloat16 word.
// Ports:
//   i_core_res [15:0]  captured core significand (unsigned Q1.15)
//   i_eres     [9:0]   signed result exponent (biased) before normalization
//   o_res      [15:0]  packed bfloat16 result, sign 0
//   o_inexact          guard|sticky (only with LAMP_SQRT_FLAGS_EN defined)
// ---------------------------------------------------------------------------
module lamp_sqrt_round_pack (
    input  logic [15:0]       i_core_res,
    input  logic signed [9:0] i_eres,
`ifdef LAMP_SQRT_FLAGS_EN
    output logic              o_inexact,
`endif
    output logic [15:0]       o_res
);
    logic [14:0]       w_norm;      // bits below the leading one after normalization
    logic signed [9:0] w_exp_norm;
    logic              w_lsb;
    logic              w_guard;
    logic              w_sticky;
    logic              w_round_up;
    logic [7:0]        w_frac_sum;

    // A significand below 1.0 is shifted up one place and the exponent drops.
    assign w_norm     = i_core_res[15] ? i_core_res[14:0] : {i_core_res[13:0], 1'b0};
    assign w_exp_norm = i_core_res[15] ? i_eres : (i_eres - 10'sd1);

    assign w_lsb      = w_norm[8];
    assign w_guard    = w_norm[7];
    assign w_sticky   = |w_norm[6:0];
    assign w_round_up = w_guard & (w_sticky | w_lsb);

    // On carry-out the 7-bit fraction wraps to zero and the exponent bumps.
    assign w_frac_sum = {1'b0, w_norm[14:8]} + {7'd0, w_round_up};

    assign o_res = {1'b0, 8'(w_exp_norm + $signed(10'(w_frac_sum[7]))), w_frac_sum[6:0]};

`ifdef LAMP_SQRT_FLAGS_EN
    assign o_inexact = w_guard | w_sticky;
`endif

endmodule

// File: rtl/lamp_sqrt_issue_unit.sv
// ---------------------------------------------------------------------------
// lamp_sqrt_issue_unit
// Front end of the LAMP square-root core: accepts a bfloat16 operand over
// valid/ready, classifies it, computes the result exponent, issues the
// significand to the core, then rounds and packs the core's answer.
// Optional feature macro: LAMP_SQRT_FLAGS_EN adds flags_o.
// Ports:
//   clk, rst (async, active-low)
//   req_valid_i / req_ready_o, op_i[15:0], inv_i      request side
//   rsp_valid_o / rsp_ready_i, res_o[15:0]            response side
//   flags_o[3:0] {invalid, divzero, inexact, timeout} (LAMP_SQRT_FLAGS_EN)
//   doSqrt_o, s_o[7:0], is_exp_odd_o, invSqrt_o,
//   special_case_o                                    issue to core
//   core_valid_i, core_res_i[15:0]                    core result
// Parameter CORE_TIMEOUT: cycles waited for the core before returning qNaN.
// ---------------------------------------------------------------------------
module lamp_sqrt_issue_unit
    import lampFPU_pkg::*;
#(
    parameter int CORE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [15:0] op_i,
    input  logic        inv_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] res_o,
`ifdef LAMP_SQRT_FLAGS_EN
    output logic [3:0]  flags_o,
`endif
    output logic        doSqrt_o,
    output logic [7:0]  s_o,
    output logic        is_exp_odd_o,
    output logic        invSqrt_o,
    output logic        special_case_o,
    input  logic        core_valid_i,
    input  logic [15:0] core_res_i
);
    localparam int CW = $clog2(CORE_TIMEOUT + 1);

    state_t            r_state, w_state_next;
    logic [CW-1:0]     r_cnt, w_cnt_next, w_cnt_inc;
    logic              w_timeout;
    logic              w_accept;
    logic              w_capture;

    class_t            w_cls;
    logic signed [9:0] w_e, w_half, w_eres;
    logic              w_special;
    logic [15:0]       w_special_res;
    logic [15:0]       w_packed;

    logic              r_req_ready, r_do_sqrt, r_rsp_valid;
    logic [15:0]       r_res;
    logic [7:0]        r_s;
    logic              r_odd, r_inv, r_special;
    logic [15:0]       r_special_res;
    logic signed [9:0] r_eres;
    logic [15:0]       r_core_res;

`ifdef LAMP_SQRT_FLAGS_EN
    logic              w_invalid, w_divzero, w_inexact;
    logic              r_invalid, r_divzero;
    logic [3:0]        r_flags;
`endif

    // r_req_ready is only high in IDLE, so it doubles as the state check.
    assign w_accept  = req_valid_i & r_req_ready;
    assign w_capture = (r_state == ST_WAIT) & core_valid_i;
    assign w_cnt_inc = r_cnt + 1'b1;

    // Operand decode, evaluated on the live request so it can be latched at accept.
    assign w_cls  = classify(op_i);
    assign w_e    = $signed({2'b00, op_i[14:7]}) - BIAS;
    assign w_half = w_e >>> 1;
    assign w_eres = inv_i ? (BIAS - w_half) : (BIAS + w_half);

    always_comb begin
        w_special     = 1'b0;
        w_special_res = 16'h0000;
        if (w_cls.is_nan || (w_cls.sign && !w_cls.is_zero)) begin
            w_special     = 1'b1;
            w_special_res = CANON_QNAN;
        end else if (w_cls.is_zero) begin
            w_special     = 1'b1;
            w_special_res = inv_i ? POS_INF : {w_cls.sign, 15'd0};
        end else if (w_cls.is_inf) begin
            w_special     = 1'b1;
            w_special_res = inv_i ? 16'h0000 : POS_INF;
        end
    end

`ifdef LAMP_SQRT_FLAGS_EN
    assign w_invalid = w_cls.is_nan | (w_cls.sign & ~w_cls.is_zero);
    assign w_divzero = w_cls.is_zero & inv_i;
`endif

    lamp_sqrt_round_pack u_round_pack (
        .i_core_res (r_core_res),
        .i_eres     (r_eres),
`ifdef LAMP_SQRT_FLAGS_EN
        .o_inexact  (w_inexact),
`endif
        .o_res      (w_packed)
    );

    // Next-state logic. A core answer in the last counted cycle beats the timeout.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_ISSUE;
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
                w_cnt_next   = '0;
            end
            ST_WAIT: begin
                if (core_valid_i) begin
                    w_state_next = ST_PACK;
                end else if (w_cnt_inc == CW'(CORE_TIMEOUT)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_OUT;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            ST_PACK:  w_state_next = ST_OUT;
            ST_OUT:   if (rsp_ready_i) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_req_ready   <= 1'b0;
            r_do_sqrt     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_res         <= 16'h0000;
            r_s           <= 8'h00;
            r_odd         <= 1'b0;
            r_inv         <= 1'b0;
            r_special     <= 1'b0;
            r_special_res <= 16'h0000;
            r_eres        <= '0;
            r_core_res    <= 16'h0000;
`ifdef LAMP_SQRT_FLAGS_EN
            r_invalid     <= 1'b0;
            r_divzero     <= 1'b0;
            r_flags       <= 4'h0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            // Handshake outputs are registered copies of the state being entered.
            r_req_ready <= (w_state_next == ST_IDLE);
            r_do_sqrt   <= (w_state_next == ST_ISSUE);
            r_rsp_valid <= (w_state_next == ST_OUT);

            if (w_accept) begin
                r_s           <= {~w_cls.is_zero, op_i[6:0]};
                r_odd         <= w_e[0];
                r_inv         <= inv_i;
                r_special     <= w_special;
                r_special_res <= w_special_res;
                r_eres        <= w_eres;
`ifdef LAMP_SQRT_FLAGS_EN
                r_invalid     <= w_invalid;
                r_divzero     <= w_divzero;
`endif
            end

            if (w_capture) begin
                r_core_res <= core_res_i;
            end

            if (w_timeout) begin
                r_res <= CANON_QNAN;
`ifdef LAMP_SQRT_FLAGS_EN
                r_flags <= 4'b0001;
`endif
            end

            if (r_state == ST_PACK) begin
                r_res <= r_special ? r_special_res : w_packed;
`ifdef LAMP_SQRT_FLAGS_EN
                r_flags <= r_special ? {r_invalid, r_divzero, 2'b00}
                                     : {2'b00, w_inexact, 1'b0};
`endif
            end
        end
    end

    assign req_ready_o    = r_req_ready;
    assign rsp_valid_o    = r_rsp_valid;
    assign res_o          = r_res;
    assign doSqrt_o       = r_do_sqrt;
    assign s_o            = r_s;
    assign is_exp_odd_o   = r_odd;
    assign invSqrt_o      = r_inv;
    assign special_case_o = r_special;
`ifdef LAMP_SQRT_FLAGS_EN
    assign flags_o        = r_flags;
`endif

endmodule

// File: tb/tb_lamp_sqrt_issue_unit.sv
module tb_lamp_sqrt_issue_unit;
    localparam int CORE_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [15:0] op_i = 16'h0000;
    logic        inv_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [15:0] res_o;
    logic        doSqrt_o;
    logic [7:0]  s_o;
    logic        is_exp_odd_o;
    logic        invSqrt_o;
    logic        special_case_o;
    logic        core_valid_i = 1'b0;
    logic [15:0] core_res_i = 16'h0000;
`ifdef LAMP_SQRT_FLAGS_EN
    logic [3:0]  flags_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lamp_sqrt_issue_unit #(.CORE_TIMEOUT(CORE_TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .op_i           (op_i),
        .inv_i          (inv_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .res_o          (res_o),
`ifdef LAMP_SQRT_FLAGS_EN
        .flags_o        (flags_o),
`endif
        .doSqrt_o       (doSqrt_o),
        .s_o            (s_o),
        .is_exp_odd_o   (is_exp_odd_o),
        .invSqrt_o      (invSqrt_o),
        .special_case_o (special_case_o),
        .core_valid_i   (core_valid_i),
        .core_res_i     (core_res_i)
    );

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic bit ref_special(input logic [15:0] op);
        int ex;
        ex = op[14:7];
        return (ex == 0) || (ex == 255) || (op[15] == 1'b1);
    endfunction

    function automatic logic [15:0] ref_result(input logic [15:0] op, input logic inv,
                                               input logic [15:0] cres);
        int ex, e, half, eres, m, q, rem;
        bit up;
        ex = op[14:7];
        if (ex == 255 && op[6:0] != 7'd0) return 16'h7FC0;
        if (op[15] && ex != 0)            return 16'h7FC0;
        if (ex == 0)   return inv ? 16'h7F80 : (op[15] ? 16'h8000 : 16'h0000);
        if (ex == 255) return inv ? 16'h0000 : 16'h7F80;
        e    = ex - 127;
        half = (e >= 0) ? (e / 2) : -((1 - e) / 2);   // floor(e/2)
        eres = inv ? (127 - half) : (127 + half);
        m    = cres;
        if (m < 32768) begin
            m    = m * 2;
            eres = eres - 1;
        end
        q   = m / 256;
        rem = m % 256;
        up  = (rem > 128) || (rem == 128 && (q % 2) == 1);
        if (up) q = q + 1;
        if (q == 256) begin
            q    = 128;
            eres = eres + 1;
        end
        return 16'(eres * 128 + (q - 128));
    endfunction

    // ---------------- transaction driver (no checking) ----------------
    task automatic drive_txn(input logic [15:0] op, input logic inv, input logic [15:0] cres,
                             input int core_dly, input int rdy_dly, input bit answer,
                             output logic [7:0] s, output logic odd, output logic invs,
                             output logic spc, output logic [15:0] res, output int lat,
                             output bit ok, output bit stable, output logic rdy_after);
        int n;
        ok = 1'b1;
        stable = 1'b1;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) ok = 1'b0;
        req_valid_i = 1'b1;
        op_i = op;
        inv_i = inv;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        op_i = 16'($urandom);
        inv_i = 1'($urandom);
        n = 0;
        while (doSqrt_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) ok = 1'b0;
        s = s_o; odd = is_exp_odd_o; invs = invSqrt_o; spc = special_case_o;
        lat = 0;
        while (rsp_valid_o !== 1'b1 && lat < 400) begin
            core_valid_i = answer && (lat == core_dly + 1);
            core_res_i   = (lat == core_dly + 1) ? cres : 16'($urandom);
            @(posedge clk); #1; lat++;
        end
        core_valid_i = 1'b0;
        if (lat >= 400) ok = 1'b0;
        res = res_o;
        for (int i = 0; i < rdy_dly; i++) begin
            if (res_o !== res || req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1) stable = 1'b0;
            @(posedge clk); #1;
        end
        if (res_o !== res || rsp_valid_o !== 1'b1) stable = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        rdy_after = req_ready_o;
        $display("txn op=%h inv=%0d core=%h dly=%0d ans=%0d -> res=%h s=%h odd=%0d spc=%0d lat=%0d",
                 op, inv, cres, core_dly, answer, res, s, odd, spc, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready_o, rsp_valid_o, doSqrt_o, s_o, is_exp_odd_o, invSqrt_o,
             special_case_o, res_o} !== 29'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0",
                     {req_ready_o, rsp_valid_o, doSqrt_o, s_o, is_exp_odd_o, invSqrt_o,
                      special_case_o, res_o});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after_release: got %b required 1", req_ready_o);
        end
    endtask

    task automatic test_directed();
        logic [15:0] d_op  [0:5];
        logic        d_inv [0:5];
        logic [15:0] d_cr  [0:5];
        logic [15:0] d_res [0:5];
        logic [7:0]  d_s   [0:5];
        logic        d_odd [0:5];
        logic        d_spc [0:5];
        logic [3:0]  d_flg [0:5];
        logic [7:0] s; logic odd, invs, spc, ra; logic [15:0] res; int lat; bit ok, st;
        d_op  = '{16'h4080, 16'h4000, 16'h4080, 16'hC080, 16'h0000, 16'h7F80};
        d_inv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        d_cr  = '{16'h8000, 16'hB505, 16'h8000, 16'h1234, 16'h1234, 16'h1234};
        d_res = '{16'h4000, 16'h3FB5, 16'h3F00, 16'h7FC0, 16'h7F80, 16'h0000};
        d_s   = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h80};
        d_odd = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        d_spc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        d_flg = '{4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0100, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            drive_txn(d_op[i], d_inv[i], d_cr[i], 0, 0, 1'b1, s, odd, invs, spc, res, lat, ok, st, ra);
            checks++;
            if (!ok || lat != 3) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d (ok=%0d) required 3", i, lat, ok);
            end
            checks++;
            if (res !== d_res[i]) begin
                failures++;
                $display("FAIL directed_res[%0d]: got %h required %h", i, res, d_res[i]);
            end
            checks++;
            if ({s, odd, invs, spc} !== {d_s[i], d_odd[i], d_inv[i], d_spc[i]}) begin
                failures++;
                $display("FAIL directed_issue[%0d]: got s=%h odd=%b inv=%b spc=%b required s=%h odd=%b inv=%b spc=%b",
                         i, s, odd, invs, spc, d_s[i], d_odd[i], d_inv[i], d_spc[i]);
            end
`ifdef LAMP_SQRT_FLAGS_EN
            checks++;
            if (flags_o !== d_flg[i]) begin
                failures++;
                $display("FAIL directed_flags[%0d]: got %b required %b", i, flags_o, d_flg[i]);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s; logic odd, invs, spc, ra; logic [15:0] res; int lat; bit ok, st;
        for (int i = 0; i < 3; i++) begin
            drive_txn(16'h4080, 1'b0, 16'h8000, 0, 0, 1'b1, s, odd, invs, spc, res, lat, ok, st, ra);
            checks++;
            if (ra !== 1'b1 || res !== 16'h4000) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got ready=%b res=%h required ready=1 res=4000", i, ra, res);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s; logic odd, invs, spc, ra; logic [15:0] res; int lat; bit ok, st;
        drive_txn(16'h4000, 1'b0, 16'hB505, 2, 10, 1'b1, s, odd, invs, spc, res, lat, ok, st, ra);
        checks++;
        if (!st || res !== 16'h3FB5) begin
            failures++;
            $display("FAIL backpressure_hold: got stable=%0d res=%h required stable=1 res=3fb5", st, res);
        end
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL backpressure_latency: got %0d required 5", lat);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] s; logic odd, invs, spc, ra; logic [15:0] res; int lat; bit ok, st;
        drive_txn(16'h4080, 1'b0, 16'h8000, 0, 0, 1'b0, s, odd, invs, spc, res, lat, ok, st, ra);
        checks++;
        if (lat != CORE_TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_latency: got %0d required %0d", lat, CORE_TIMEOUT + 1);
        end
        checks++;
        if (res !== 16'h7FC0) begin
            failures++;
            $display("FAIL timeout_res: got %h required 7fc0", res);
        end
`ifdef LAMP_SQRT_FLAGS_EN
        checks++;
        if (flags_o !== 4'b0001) begin
            failures++;
            $display("FAIL timeout_flags: got %b required 0001", flags_o);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] s; logic odd, invs, spc, ra; logic [15:0] res; int lat; bit ok, st;
        logic [15:0] op, cres, exp_res; logic inv; logic [7:0] ex; logic [6:0] fr;
        int dly, e_unb;
        bit exp_odd;
        for (int i = 0; i < 40; i++) begin
            ex = 8'($urandom_range(1, 254));
            fr = 7'($urandom);
            op = ($urandom_range(0, 3) != 0) ? {1'b0, ex, fr} : 16'($urandom);
            inv  = 1'($urandom);
            cres = 16'($urandom_range(16'h4000, 16'hFFFF));
            dly  = $urandom_range(0, 4);
            drive_txn(op, inv, cres, dly, $urandom_range(0, 3), 1'b1,
                      s, odd, invs, spc, res, lat, ok, st, ra);
            exp_res = ref_result(op, inv, cres);
            e_unb   = int'(op[14:7]) - 127;
            exp_odd = (e_unb % 2) != 0;
            checks++;
            if (res !== exp_res) begin
                failures++;
                $display("FAIL random_res[%0d] op=%h inv=%0d core=%h: got %h required %h",
                         i, op, inv, cres, res, exp_res);
            end
            checks++;
            if ({s, odd, invs, spc} !== {op[14:7] != 8'd0, op[6:0], exp_odd, inv, ref_special(op)}) begin
                failures++;
                $display("FAIL random_issue[%0d] op=%h: got s=%h odd=%b inv=%b spc=%b", i, op, s, odd, invs, spc);
            end
            checks++;
            if (!ok || !st || lat != dly + 3) begin
                failures++;
                $display("FAIL random_timing[%0d]: got lat=%0d ok=%0d stable=%0d required lat=%0d",
                         i, lat, ok, st, dly + 3);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int n;
        int bad;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        req_valid_i = 1'b1; op_i = 16'h4080; inv_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;   // first WAIT cycle
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({req_ready_o, rsp_valid_o, doSqrt_o, s_o, is_exp_odd_o, invSqrt_o,
             special_case_o, res_o} !== 29'd0) begin
            failures++;
            $display("FAIL reset_in_wait_outputs: got %h required 0",
                     {req_ready_o, rsp_valid_o, doSqrt_o, s_o, is_exp_odd_o, invSqrt_o,
                      special_case_o, res_o});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        core_valid_i = 1'b1; core_res_i = 16'h8000;
        @(posedge clk); #1;
        core_valid_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid_o !== 1'b0 || doSqrt_o !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_wait_late_core: got %0d stray cycles ready=%b required 0 and ready=1",
                     bad, req_ready_o);
        end
        $display("txn reset during WAIT, late core_valid injected");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_random();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
